// File: rtl/volatility_scheduler.sv
// One-at-a-time issue scheduler for the volatility unit: per-stock coalescing quote slots,
// round-robin grant, then wait for completion or timeout. Optional macro: VOL_SCHED_OVERWRITE_CNT_EN.
module volatility_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_STOCKS     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_quote_valid,
  input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
  input  logic [DATA_WIDTH-1:0]         i_best_ask,
  input  logic [DATA_WIDTH-1:0]         i_best_bid,
  input  logic                          i_vol_data_valid,
  output logic                          o_vol_data_valid,
  output logic [$clog2(NUM_STOCKS)-1:0] o_vol_stock_id,
  output logic [DATA_WIDTH-1:0]         o_vol_best_ask,
  output logic [DATA_WIDTH-1:0]         o_vol_best_bid,
  output logic [NUM_STOCKS-1:0]         o_pending,
  output logic                          o_busy,
  output logic                          o_timeout_err,
  output logic [CNT_WIDTH-1:0]          o_overwrite_count
);

  localparam int ID_W   = $clog2(NUM_STOCKS);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                  state, next_state;
  logic [NUM_STOCKS-1:0]   slot_valid;
  logic [DATA_WIDTH-1:0]   slot_ask [NUM_STOCKS];
  logic [DATA_WIDTH-1:0]   slot_bid [NUM_STOCKS];
  logic [ID_W-1:0]         ptr;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [ID_W-1:0]         grant;
  logic                    grant_found;
  logic                    issue;
  logic                    timeout_hit;

  // Round-robin search starting just after the last granted stock.
  always_comb begin
    logic [ID_W:0] sum;
    // NOTE: every variable written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant       = '0;
    grant_found = 1'b0;
    sum         = '0;
    for (int k = 1; k <= NUM_STOCKS; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_STOCKS)) sum = sum - (ID_W+1)'(NUM_STOCKS);
      if (!grant_found && slot_valid[sum[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant       = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    next_state  = state;
    issue       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_found) begin
          issue      = 1'b1;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_vol_data_valid) begin
          next_state = ST_IDLE;
        end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES-1)) begin
          timeout_hit = 1'b1;
          next_state  = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= next_state;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr              <= ID_W'(NUM_STOCKS-1);
      wait_cnt         <= '0;
      o_vol_data_valid <= 1'b0;
      o_vol_stock_id   <= '0;
      o_vol_best_ask   <= '0;
      o_vol_best_bid   <= '0;
      o_timeout_err    <= 1'b0;
    end else begin
      o_vol_data_valid <= issue;
      if (issue) begin
        o_vol_stock_id <= grant;
        o_vol_best_ask <= slot_ask[grant];
        o_vol_best_bid <= slot_bid[grant];
        ptr            <= grant;
        wait_cnt       <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) o_timeout_err <= 1'b1;
    end
  end

  // A write on the grant edge re-arms the slot, so the new quote is served later.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_STOCKS; i++) begin
        if (i_quote_valid && i_stock_id == ID_W'(i))
          slot_valid[i] <= 1'b1;
        else if (issue && grant == ID_W'(i))
          slot_valid[i] <= 1'b0;
      end
    end
  end

  // NOTE: slot payload storage is not reset; a slot's contents are only observed
  // while its valid bit is set, and the valid bits are reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_STOCKS; i++) begin
      if (i_quote_valid && i_stock_id == ID_W'(i)) begin
        slot_ask[i] <= i_best_ask;
        slot_bid[i] <= i_best_bid;
      end
    end
  end

  assign o_pending = slot_valid;
  assign o_busy    = (state == ST_WAIT);

`ifdef VOL_SCHED_OVERWRITE_CNT_EN
  logic                 overwrite;
  logic [CNT_WIDTH-1:0] overwrite_cnt;

  always_comb begin
    overwrite = 1'b0;
    for (int i = 0; i < NUM_STOCKS; i++) begin
      if (i_quote_valid && i_stock_id == ID_W'(i) && slot_valid[i]) overwrite = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                         overwrite_cnt <= '0;
    else if (overwrite && overwrite_cnt != '1) overwrite_cnt <= overwrite_cnt + 1'b1;
  end

  assign o_overwrite_count = overwrite_cnt;
`else
  assign o_overwrite_count = '0;
`endif

endmodule

// File: tb/tb_volatility_scheduler.sv
// Directed bench for volatility_scheduler: scoreboard of expected issues popped by an
// output monitor, plus immediate-assertion checks of status outputs at each step.
module tb_volatility_scheduler;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 64;
  localparam int CW = 16;
  localparam int IW = 2;

`ifdef VOL_SCHED_OVERWRITE_CNT_EN
  localparam bit OVW_EN = 1'b1;
`else
  localparam bit OVW_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_quote_valid = 1'b0;
  logic [IW-1:0] i_stock_id = '0;
  logic [DW-1:0] i_best_ask = '0;
  logic [DW-1:0] i_best_bid = '0;
  logic          i_vol_data_valid = 1'b0;
  logic          o_vol_data_valid;
  logic [IW-1:0] o_vol_stock_id;
  logic [DW-1:0] o_vol_best_ask;
  logic [DW-1:0] o_vol_best_bid;
  logic [NS-1:0] o_pending;
  logic          o_busy;
  logic          o_timeout_err;
  logic [CW-1:0] o_overwrite_count;

  volatility_scheduler #(
    .DATA_WIDTH(DW), .NUM_STOCKS(NS), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_quote_valid(i_quote_valid), .i_stock_id(i_stock_id),
    .i_best_ask(i_best_ask), .i_best_bid(i_best_bid),
    .i_vol_data_valid(i_vol_data_valid),
    .o_vol_data_valid(o_vol_data_valid), .o_vol_stock_id(o_vol_stock_id),
    .o_vol_best_ask(o_vol_best_ask), .o_vol_best_bid(o_vol_best_bid),
    .o_pending(o_pending), .o_busy(o_busy), .o_timeout_err(o_timeout_err),
    .o_overwrite_count(o_overwrite_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] ask;
    logic [DW-1:0] bid;
  } issue_t;

  issue_t sb_q[$];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] ovw_exp(input int n);
    return OVW_EN ? CW'(n) : '0;
  endfunction

  // Every issue pulse must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (i_reset_n && o_vol_data_valid) begin
      if (sb_q.size() == 0) begin
        check("issue_unexpected_sb_size", 64'(sb_q.size()), 64'd1);
      end else begin
        issue_t e;
        e = sb_q.pop_front();
        check("issue_id",  64'(o_vol_stock_id), 64'(e.id));
        check("issue_ask", 64'(o_vol_best_ask), 64'(e.ask));
        check("issue_bid", 64'(o_vol_best_bid), 64'(e.bid));
      end
    end
  end

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] ask, input logic [DW-1:0] bid);
    issue_t e;
    e.id  = IW'(id);
    e.ask = ask;
    e.bid = bid;
    sb_q.push_back(e);
  endtask

  task automatic send(input int id, input logic [DW-1:0] ask, input logic [DW-1:0] bid);
    i_quote_valid = 1'b1;
    i_stock_id    = IW'(id);
    i_best_ask    = ask;
    i_best_bid    = bid;
    cycle();
    i_quote_valid = 1'b0;
  endtask

  task automatic complete();
    i_vol_data_valid = 1'b1;
    cycle();
    i_vol_data_valid = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    while (o_vol_data_valid !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    check({tag, "_issue_seen"}, 64'(o_vol_data_valid), 64'd1);
  endtask

  task automatic do_reset();
    i_reset_n        = 1'b0;
    i_quote_valid    = 1'b0;
    i_vol_data_valid = 1'b0;
    repeat (2) cycle();
    i_reset_n = 1'b1;
    cycle();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    // Reset state.
    #2;
    check("rst_valid",   64'(o_vol_data_valid), 64'd0);
    check("rst_pending", 64'(o_pending),        64'd0);
    check("rst_busy",    64'(o_busy),           64'd0);
    check("rst_tmo",     64'(o_timeout_err),    64'd0);
    check("rst_ovw",     64'(o_overwrite_count), 64'd0);
    do_reset();

    // Single issue, completion on the third WAIT cycle.
    push_exp(2, 32'h100, 32'hF0);
    send(2, 32'h100, 32'hF0);
    check("t1_pending_set", 64'(o_pending), 64'b0100);
    check("t1_no_issue_yet", 64'(o_vol_data_valid), 64'd0);
    cycle();
    check("t1_issue",       64'(o_vol_data_valid), 64'd1);
    check("t1_busy",        64'(o_busy), 64'd1);
    check("t1_pending_clr", 64'(o_pending), 64'd0);
    cycle();
    check("t1_single_pulse", 64'(o_vol_data_valid), 64'd0);
    cycle();
    check("t1_busy_w3", 64'(o_busy), 64'd1);
    complete();
    check("t1_idle",    64'(o_busy), 64'd0);
    check("t1_pending", 64'(o_pending), 64'd0);

    // Round-robin over a burst, then stock 0 ahead of stock 1.
    do_reset();
    push_exp(0, 32'h10, 32'h11);
    push_exp(1, 32'h20, 32'h21);
    push_exp(3, 32'h30, 32'h31);
    send(0, 32'h10, 32'h11);
    send(1, 32'h20, 32'h21);
    send(3, 32'h30, 32'h31);
    check("t2_busy",    64'(o_busy), 64'd1);
    check("t2_pending", 64'(o_pending), 64'b1010);
    complete();
    wait_issue("t2_b");
    complete();
    wait_issue("t2_c");
    push_exp(0, 32'h50, 32'h51);
    push_exp(1, 32'h40, 32'h41);
    send(1, 32'h40, 32'h41);
    send(0, 32'h50, 32'h51);
    check("t2_pending2", 64'(o_pending), 64'b0011);
    complete();
    wait_issue("t2_d");
    complete();
    wait_issue("t2_e");
    complete();
    check("t2_drained", 64'(o_pending), 64'd0);

    // Coalescing of three stock-1 quotes while busy on stock 0.
    do_reset();
    push_exp(0, 32'hA0, 32'hA1);
    send(0, 32'hA0, 32'hA1);
    wait_issue("t3_a");
    send(1, 32'd10, 32'd9);
    send(1, 32'd20, 32'd19);
    send(1, 32'd30, 32'd29);
    push_exp(1, 32'd30, 32'd29);
    check("t3_pending", 64'(o_pending), 64'b0010);
    check("t3_ovw",     64'(o_overwrite_count), 64'(ovw_exp(2)));
    complete();
    wait_issue("t3_b");
    complete();
    repeat (3) cycle();
    check("t3_idle",    64'(o_busy), 64'd0);
    check("t3_pending_clr", 64'(o_pending), 64'd0);

    // Write to stock 0 on the edge that grants stock 0.
    do_reset();
    push_exp(0, 32'h111, 32'h110);
    push_exp(0, 32'h222, 32'h220);
    send(0, 32'h111, 32'h110);
    send(0, 32'h222, 32'h220);
    check("t4_issue",   64'(o_vol_data_valid), 64'd1);
    check("t4_pending", 64'(o_pending), 64'b0001);
    check("t4_ovw",     64'(o_overwrite_count), 64'(ovw_exp(1)));
    complete();
    wait_issue("t4_reissue");
    complete();
    check("t4_pending_clr", 64'(o_pending), 64'd0);

    // Timeout after exactly TO cycles, next stock issued, late completion ignored.
    do_reset();
    push_exp(1, 32'h1234, 32'h1230);
    push_exp(2, 32'h5678, 32'h5670);
    send(1, 32'h1234, 32'h1230);
    send(2, 32'h5678, 32'h5670);
    check("t5_issue", 64'(o_vol_data_valid), 64'd1);
    repeat (TO - 1) cycle();
    check("t5_tmo_early",  64'(o_timeout_err), 64'd0);
    check("t5_busy_early", 64'(o_busy), 64'd1);
    cycle();
    check("t5_tmo_set", 64'(o_timeout_err), 64'd1);
    check("t5_idle",    64'(o_busy), 64'd0);
    i_vol_data_valid = 1'b1;
    cycle();
    i_vol_data_valid = 1'b0;
    check("t5_next_issue", 64'(o_vol_data_valid), 64'd1);
    cycle();
    check("t5_late_ignored", 64'(o_busy), 64'd1);
    check("t5_tmo_sticky",   64'(o_timeout_err), 64'd1);
    complete();
    check("t5_done",        64'(o_busy), 64'd0);
    check("t5_tmo_sticky2", 64'(o_timeout_err), 64'd1);

    // Asynchronous reset mid-WAIT.
    do_reset();
    push_exp(2, 32'hBEEF, 32'hBEE0);
    send(2, 32'hBEEF, 32'hBEE0);
    wait_issue("t6_a");
    send(1, 32'hCAFE, 32'hCAF0);
    check("t6_pending_pre", 64'(o_pending), 64'b0010);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("t6_valid", 64'(o_vol_data_valid), 64'd0);
    check("t6_id",    64'(o_vol_stock_id), 64'd0);
    check("t6_ask",   64'(o_vol_best_ask), 64'd0);
    check("t6_bid",   64'(o_vol_best_bid), 64'd0);
    check("t6_pending", 64'(o_pending), 64'd0);
    check("t6_busy",  64'(o_busy), 64'd0);
    check("t6_tmo",   64'(o_timeout_err), 64'd0);
    check("t6_ovw",   64'(o_overwrite_count), 64'd0);
    cycle();
    i_reset_n        = 1'b1;
    i_vol_data_valid = 1'b1;
    cycle();
    i_vol_data_valid = 1'b0;
    repeat (3) cycle();
    check("t6_idle_after", 64'(o_busy), 64'd0);
    check("t6_no_stale",   64'(o_pending), 64'd0);
    push_exp(3, 32'h3, 32'h2);
    send(3, 32'h3, 32'h2);
    wait_issue("t6_b");
    push_exp(0, 32'h7, 32'h6);
    push_exp(1, 32'h5, 32'h4);
    send(1, 32'h5, 32'h4);
    send(0, 32'h7, 32'h6);
    complete();
    wait_issue("t6_c");
    complete();
    wait_issue("t6_d");
    complete();

    repeat (4) cycle();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/volatility_scheduler.md
# volatility_scheduler

Sequences quote updates into the per-stock volatility unit so that it runs one computation at a time. Holds one pending best-bid/best-ask slot per stock and round-robins among pending stocks. Issues a single-cycle valid pulse to the volatility unit, then waits for its completion pulse or a timeout before issuing the next update. Sits between the order-book top-of-book stage and the volatility unit.

## Interface
- DATA_WIDTH, 32, price word width
- NUM_STOCKS, 4, number of stocks and pending slots (≥2)
- TIMEOUT_CYCLES, 64, maximum wait for completion, in cycles (≥2)
- CNT_WIDTH, 16, overwrite counter width

- i_clk  in  1  single clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_quote_valid  in  1  new quote this cycle; always accepted, no backpressure
- i_stock_id  in  $clog2(NUM_STOCKS)  stock of the incoming quote
- i_best_ask  in  DATA_WIDTH  incoming best ask
- i_best_bid  in  DATA_WIDTH  incoming best bid
- i_vol_data_valid  in  1  completion pulse from the volatility unit
- o_vol_data_valid  out  1  one-cycle issue pulse to the volatility unit
- o_vol_stock_id  out  $clog2(NUM_STOCKS)  issued stock
- o_vol_best_ask  out  DATA_WIDTH  issued ask
- o_vol_best_bid  out  DATA_WIDTH  issued bid
- o_pending  out  NUM_STOCKS  per-stock pending-slot valid bits
- o_busy  out  1  high while in WAIT
- o_timeout_err  out  1  sticky; set on a completion timeout
- o_overwrite_count  out  CNT_WIDTH  saturating count of quotes that overwrote a pending slot

## Operation
- **Reset.** All outputs are 0. Slots are empty. State is IDLE. Round-robin pointer = NUM_STOCKS-1, so stock 0 has priority first. Wait counter = 0.
- **Slot write.** On i_quote_valid, slot[i_stock_id] takes {ask, bid} and its valid bit is set.
  - If the slot was already valid, the old quote is discarded (coalescing).
- **Arbitration.** A combinational round-robin search starts at pointer+1, wraps modulo NUM_STOCKS, and returns the first valid slot.
- **FSM states:** IDLE and WAIT.
- **IDLE.** If any slot is valid (registered state only):
  - Load the o_vol_* registers from the granted slot and assert o_vol_data_valid for one cycle.
  - Clear the granted slot's valid bit. Set pointer = grant. Clear the wait counter. Go to WAIT.
  - i_vol_data_valid is ignored in IDLE.
- **WAIT.** o_busy = 1. The counter increments every cycle.
  - If i_vol_data_valid = 1: go to IDLE. This includes the first WAIT cycle, the one carrying the issue pulse.
  - Else if counter = TIMEOUT_CYCLES-1: set o_timeout_err and go to IDLE.
- **Simultaneous write and grant to the same stock.** The write wins: the slot stays valid with the new data, and the issued data is the old slot contents.
- **Quotes to other stocks** are accepted in any state.
- **o_timeout_err** is cleared only by reset.
- **Reset mid-WAIT.** The outstanding completion is abandoned. A late i_vol_data_valid arriving in IDLE is ignored.

## Timing
- Quote sampled at edge t → o_pending bit visible after edge t → o_vol_data_valid high in the cycle after edge t+1. Minimum input-to-issue latency is 2 edges.
- Completion sampled at edge c → IDLE after c → next issue pulse after edge c+1. Minimum issue spacing is 2 cycles.
- On timeout, the issue-to-IDLE time is exactly TIMEOUT_CYCLES cycles.
- All outputs are registered.

## Configuration
- **VOL_SCHED_OVERWRITE_CNT_EN defined:** o_overwrite_count increments by 1 on every overwriting write.
  - This includes the simultaneous write-and-grant case, because the old data was still in the slot.
  - The counter saturates at 2^CNT_WIDTH-1.
- **Not defined:** the counter logic is absent and o_overwrite_count is tied to 0. All other behaviour is identical.

## Test plan
- **Single issue.** Quote stock 2, ask=0x100, bid=0xF0. → o_vol_data_valid pulses 2 edges later with id=2 and the same prices. → Completion on the 3rd WAIT cycle returns to IDLE; o_pending=0.
- **Round-robin.** Quotes for stocks 0, 1, 3 in one burst; each completion arrives 1 cycle after its issue. → Issue order 0, 1, 3. → A new stock-0 quote is then served before any re-served stock 1.
- **Coalescing.** Three stock-1 quotes with asks 10, 20, 30 while busy on stock 0. → Stock 1 is issued once with ask=30. → o_overwrite_count=2 with the macro, 0 without.
- **Simultaneous write and grant.** Stock-0 quote on the same edge that stock 0 is granted. → Old data is issued; o_pending[0] stays 1; stock 0 is re-issued with the new data after completion.
- **Timeout.** Issue with no completion. → o_timeout_err rises exactly TIMEOUT_CYCLES cycles after the issue pulse and stays set. → The next pending stock is issued; a late completion in IDLE has no effect.
- **Async reset mid-WAIT.** Assert i_reset_n=0 between edges. → All outputs are 0 immediately. → After release, stock 0 has priority.
